mem_rr_arbiter: RTL

Two-master round-robin arbiter for the native valid/ready memory interface (valid/addr/wdata/wstrb in, rdata/ready out). It lets a second bus master, such as a DMA engine or debug port, share the path into the SoC bus alongside the PicoRV32 core. It holds the grant for the full duration of each transaction and guards it with a response-timeout watchdog. A transaction that times out completes with error data and sets a sticky error flag.

---
 rtl/mem_rr_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_rr_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory interface.
// The grant is held for a whole transaction, and a response watchdog forces
// completion with error data when the downstream slave never answers.
module mem_rr_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [1:0]       m_valid_i,
    input  logic [1:0][31:0] m_addr_i,
    input  logic [1:0][31:0] m_wdata_i,
    input  logic [1:0][3:0]  m_wstrb_i,
    output logic [31:0]      m_rdata_o,
    output logic [1:0]       m_ready_o,
    output logic             s_valid_o,
    output logic [31:0]      s_addr_o,
    output logic [31:0]      s_wdata_o,
    output logic [3:0]       s_wstrb_o,
    input  logic [31:0]      s_rdata_i,
    input  logic             s_ready_i,
    output logic [1:0]       grant_o,
    output logic             err_o,
    output logic [31:0]      err_addr_o,
    input  logic             err_clr_i
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    // A zero timeout disables the watchdog; CntLast is the count value of the final BUSY cycle.
    localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] CntLast   = TimeoutEn ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;

    // Next-state and output decode: arbitration in IDLE, pass-through/watchdog in BUSY.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        err_d      = err_q & ~err_clr_i;
        err_addr_d = err_addr_q;

        m_rdata_o  = '0;
        m_ready_o  = '0;
        s_valid_o  = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        s_wstrb_o  = '0;
        grant_o    = '0;

        unique case (state_q)
            StIdle: begin
                if (|m_valid_i) begin
                    // Contention goes to the master not served last; otherwise the lone requester.
                    gnt_d   = (m_valid_i == 2'b11) ? ~last_q : m_valid_i[1];
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                grant_o   = gnt_q ? 2'b10 : 2'b01;
                s_addr_o  = m_addr_i[gnt_q];
                s_wdata_o = m_wdata_i[gnt_q];
                s_wstrb_o = m_wstrb_i[gnt_q];
                if (!m_valid_i[gnt_q]) begin
                    // Master withdrew its request: release silently.
                    last_d  = gnt_q;
                    state_d = StIdle;
                end else if (s_ready_i) begin
                    // Ready beats a coincident timeout.
                    s_valid_o        = 1'b1;
                    m_ready_o[gnt_q] = 1'b1;
                    m_rdata_o        = s_rdata_i;
                    last_d           = gnt_q;
                    state_d          = StIdle;
                end else if (TimeoutEn && (cnt_q == CntLast)) begin
                    m_ready_o[gnt_q] = 1'b1;
                    m_rdata_o        = ERR_RDATA;
                    err_d            = 1'b1;
                    err_addr_d       = m_addr_i[gnt_q];
                    last_d           = gnt_q;
                    state_d          = StIdle;
                end else begin
                    s_valid_o = 1'b1;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        err_o      = err_q;
        err_addr_o = err_addr_q;
    end

    // State registers with synchronous active-low reset; master 0 has first priority.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule
